// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, flag bit positions.
// Ports: none (package).
// Imported by seq_alu and alu_comb_core.
package seq_alu_pkg;

    // Operation codes (4-bit op field); 12..15 are reserved.
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_OR  = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_ADC = 4'd8;
    localparam logic [3:0] OP_SBC = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;
    localparam logic [3:0] OP_XOR = 4'd11;

    // Bit positions inside the 4-bit {C,N,O,Z} flags word.
    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_O = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SHR) || (op == OP_SHL);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Combinational single-cycle ALU datapath: result plus carry and signed-overflow.
// Ports: op, a, b, c_in (registered carry) in; result, c_out, o_out, reserved out.
// Shift/MUL opcodes pass A through (used for zero-length shifts); reserved gives 0.
module alu_comb_core
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             o_out,
    output logic             reserved
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           c_add;
    logic           c_sub;

    always_comb begin
        c_add    = (op == OP_ADC) ? c_in : 1'b0;
        c_sub    = (op == OP_SBC) ? c_in : 1'b0;
        sum      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_add};
        // Bit WIDTH of the extended difference is the borrow.
        diff     = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, c_sub};
        result   = '0;
        c_out    = 1'b0;
        o_out    = 1'b0;
        reserved = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                result = sum[WIDTH-1:0];
                c_out  = sum[WIDTH];
                o_out  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_SBC: begin
                result = diff[WIDTH-1:0];
                c_out  = diff[WIDTH];
                o_out  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_OR:  result = a | b;
            OP_AND: result = a & b;
            OP_NOT: result = ~a;
            OP_XOR: result = a ^ b;
            OP_CMP: result = {{(WIDTH-1){1'b0}}, (a == b)};
            OP_SHR, OP_SHL, OP_MUL: result = a;
            default: reserved = 1'b1;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops via alu_comb_core, bit-serial shifts and shift-add multiply.
// Ports: clk, reset, start, op, in_A, in_B, in_enable_out in; out (tri-stated), flags, busy, done out.
// Latency 1 edge for single-cycle ops, a edges for shifts, WIDTH edges for MUL; start ignored while busy.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic             in_enable_out,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             done
);

    localparam int                 CNT_W     = $clog2(WIDTH + 1);
    localparam logic [SHAMT_W-1:0] SHAMT_MAX = SHAMT_W'(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_MUL   = CNT_W'(WIDTH);

    state_t state_q, state_d;

    // Architectural (published) state.
    logic [WIDTH-1:0] out_q;
    logic [3:0]       flags_q;
    logic             done_q;

    // Working state; never visible on out until the publish edge.
    logic [WIDTH-1:0]   sh_q;
    logic               sh_left_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;

    // FSM control strobes.
    logic ld_core, ld_shift, ld_mul, pub_shift, pub_mul;

    // Single-cycle datapath.
    logic [WIDTH-1:0] core_res;
    logic             core_c, core_o, core_rsvd;

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .op       (op),
        .a        (in_A),
        .b        (in_B),
        .c_in     (flags_q[FLAG_C]),
        .result   (core_res),
        .c_out    (core_c),
        .o_out    (core_o),
        .reserved (core_rsvd)
    );

    // Shift amount, clamped so an oversize request shifts every bit out.
    logic [SHAMT_W-1:0] shamt_raw, shamt_a;
    assign shamt_raw = in_B[SHAMT_W-1:0];
    assign shamt_a   = (shamt_raw > SHAMT_MAX) ? SHAMT_MAX : shamt_raw;

    // One shift step and one partial-product step, from the working registers.
    logic [WIDTH-1:0]   sh_next;
    logic               sh_bit;
    logic [2*WIDTH-1:0] acc_next;
    logic               last_step;

    assign sh_next   = sh_left_q ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
    assign sh_bit    = sh_left_q ? sh_q[WIDTH-1] : sh_q[0];
    assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last_step = (cnt_q == CNT_ONE);

    function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r,
                                              input logic c, input logic o);
        logic [3:0] f;
        f         = '0;
        f[FLAG_C] = c;
        f[FLAG_N] = r[WIDTH-1];
        f[FLAG_O] = o;
        f[FLAG_Z] = (r == '0);
        return f;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ld_core   = 1'b0;
        ld_shift  = 1'b0;
        ld_mul    = 1'b0;
        pub_shift = 1'b0;
        pub_mul   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_shift(op) && (shamt_a != '0)) begin
                        ld_shift = 1'b1;
                        state_d  = SHIFT;
                    end else if (op == OP_MUL) begin
                        ld_mul  = 1'b1;
                        state_d = MUL;
                    end else begin
                        // Includes zero-length shifts, which return A.
                        ld_core = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (last_step) begin
                    pub_shift = 1'b1;
                    state_d   = IDLE;
                end
            end
            MUL: begin
                if (last_step) begin
                    pub_mul = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q     <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
            sh_q      <= '0;
            sh_left_q <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
        end else begin
            done_q <= ld_core | pub_shift | pub_mul;

            if (ld_core) begin
                out_q <= core_res;
                if (!core_rsvd) begin
                    flags_q <= pack_flags(core_res, core_c, core_o);
                end
            end

            if (ld_shift) begin
                sh_q      <= in_A;
                sh_left_q <= (op == OP_SHL);
                cnt_q     <= CNT_W'(shamt_a);
            end else if (state_q == SHIFT) begin
                sh_q  <= sh_next;
                cnt_q <= cnt_q - CNT_ONE;
                if (pub_shift) begin
                    out_q   <= sh_next;
                    flags_q <= pack_flags(sh_next, sh_bit, 1'b0);
                end
            end

            if (ld_mul) begin
                acc_q    <= '0;
                mcand_q  <= {{WIDTH{1'b0}}, in_A};
                mplier_q <= in_B;
                cnt_q    <= CNT_MUL;
            end else if (state_q == MUL) begin
                acc_q    <= acc_next;
                mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
                mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
                cnt_q    <= cnt_q - CNT_ONE;
                if (pub_mul) begin
                    out_q   <= acc_next[WIDTH-1:0];
                    // Carry reports that the product did not fit in WIDTH bits.
                    flags_q <= pack_flags(acc_next[WIDTH-1:0], |acc_next[2*WIDTH-1:WIDTH], 1'b0);
                end
            end
        end
    end

    assign out   = in_enable_out ? out_q : {WIDTH{1'bz}};
    assign flags = flags_q;
    assign busy  = (state_q != IDLE);
    assign done  = done_q;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
    import seq_alu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] op;
    logic [7:0] in_A, in_B;
    logic       in_enable_out;
    wire  [7:0] out;
    logic [3:0] flags;
    logic       busy, done;

    int n_cmp = 0;
    int n_err = 0;

    seq_alu #(.WIDTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .op            (op),
        .in_A          (in_A),
        .in_B          (in_B),
        .in_enable_out (in_enable_out),
        .out           (out),
        .flags         (flags),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic [3:0] f;   // {C,N,O,Z}
    } vec_t;

    // Applied in order: ADC/SBC rely on the carry left by the preceding entry.
    vec_t tv [13] = '{
        '{OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b0110},
        '{OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b1001},
        '{OP_ADC, 8'h00, 8'h00, 8'h01, 4'b0000},
        '{OP_SUB, 8'h00, 8'h01, 8'hFF, 4'b1100},
        '{OP_SBC, 8'h05, 8'h02, 8'h02, 4'b0000},
        '{OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b0010},
        '{OP_XOR, 8'hA5, 8'hFF, 8'h5A, 4'b0000},
        '{OP_NOT, 8'h0F, 8'h00, 8'hF0, 4'b0100},
        '{OP_CMP, 8'h33, 8'h33, 8'h01, 4'b0000},
        '{OP_CMP, 8'h33, 8'h34, 8'h00, 4'b0001},
        '{OP_OR,  8'h0C, 8'h30, 8'h3C, 4'b0000},
        '{OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000},
        '{OP_SHL, 8'h5A, 8'h00, 8'h5A, 4'b0000}
    };

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the start edge E0.
    task automatic kick(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
        op    = o;
        in_A  = a;
        in_B  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges after E0 until done is seen; 40 means the bound expired.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int ndone;
        int done_at;

        reset = 1'b1; start = 1'b0; op = '0; in_A = '0; in_B = '0; in_enable_out = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst out",   {8'h0, out},   16'h0000);
        chk("rst flags", {12'h0, flags}, 16'h0000);
        chk("rst busy",  {15'h0, busy},  16'h0000);
        chk("rst done",  {15'h0, done},  16'h0000);
        reset = 1'b0;
        @(negedge clk);

        // Single-cycle operations: result at E0, done for exactly one cycle.
        for (int i = 0; i < 13; i++) begin
            kick(tv[i].op, tv[i].a, tv[i].b);
            chk($sformatf("tbl%0d done", i),  {15'h0, done},  16'h0001);
            chk($sformatf("tbl%0d busy", i),  {15'h0, busy},  16'h0000);
            chk($sformatf("tbl%0d out", i),   {8'h0, out},    {8'h0, tv[i].y});
            chk($sformatf("tbl%0d flags", i), {12'h0, flags}, {12'h0, tv[i].f});
            @(negedge clk);
            chk($sformatf("tbl%0d done drop", i), {15'h0, done}, 16'h0000);
        end

        // SHR 0x01 by 1: busy one cycle, publishes at E0+1.
        kick(OP_SHR, 8'h01, 8'h01);
        chk("shr1 busy", {15'h0, busy}, 16'h0001);
        chk("shr1 done", {15'h0, done}, 16'h0000);
        chk("shr1 hold", {8'h0, out},   16'h005A);
        @(negedge clk);
        chk("shr1 done e1", {15'h0, done},  16'h0001);
        chk("shr1 busy e1", {15'h0, busy},  16'h0000);
        chk("shr1 out",     {8'h0, out},    16'h0000);
        chk("shr1 flags",   {12'h0, flags}, 16'h0009);

        // SHL 0x81 by 3: busy for 3 cycles, out holds old value until E0+3.
        @(negedge clk);
        kick(OP_SHL, 8'h81, 8'h03);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("shl3 busy k%0d", k), {15'h0, busy}, 16'h0001);
            chk($sformatf("shl3 done k%0d", k), {15'h0, done}, 16'h0000);
            chk($sformatf("shl3 hold k%0d", k), {8'h0, out},   16'h0000);
            @(negedge clk);
        end
        chk("shl3 done", {15'h0, done},  16'h0001);
        chk("shl3 busy", {15'h0, busy},  16'h0000);
        chk("shl3 out",  {8'h0, out},    16'h0008);
        chk("shl3 flags", {12'h0, flags}, 16'h0000);

        // Oversize shift amount (low bits 0xF) clamps to 8 steps.
        @(negedge clk);
        kick(OP_SHR, 8'h80, 8'hFF);
        wait_done(cyc);
        chk("shr clamp lat",   cyc[15:0],     16'd8);
        chk("shr clamp out",   {8'h0, out},   16'h0000);
        chk("shr clamp flags", {12'h0, flags}, 16'h0009);

        // MUL 0x0F*0x11 with a start pulse while busy that must be ignored.
        @(negedge clk);
        kick(OP_MUL, 8'h0F, 8'h11);
        ndone = 0;
        done_at = -1;
        for (int k = 0; k < 12; k++) begin
            if (done === 1'b1) begin
                ndone++;
                done_at = k;
            end
            if (k < 8) chk($sformatf("mul hold k%0d", k), {8'h0, out}, 16'h0000);
            if (k == 2) begin
                op = OP_ADD; in_A = 8'h01; in_B = 8'h01; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (k == 8) begin
                chk("mul out",   {8'h0, out},    16'h00FF);
                chk("mul flags", {12'h0, flags}, 16'h0004);
            end
            @(negedge clk);
        end
        chk("mul ndone",   ndone[15:0],   16'd1);
        chk("mul done_at", done_at[15:0], 16'd8);
        chk("mul keep",    {8'h0, out},   16'h00FF);

        // Reserved opcode: out cleared, flags untouched, done still pulses.
        kick(4'd12, 8'hAA, 8'h55);
        chk("rsv done",  {15'h0, done},  16'h0001);
        chk("rsv out",   {8'h0, out},    16'h0000);
        chk("rsv flags", {12'h0, flags}, 16'h0004);
        @(negedge clk);

        // MUL 0x10*0x10: product overflows WIDTH.
        kick(OP_MUL, 8'h10, 8'h10);
        wait_done(cyc);
        chk("mul2 lat",   cyc[15:0],     16'd8);
        chk("mul2 out",   {8'h0, out},   16'h0000);
        chk("mul2 flags", {12'h0, flags}, 16'h0009);
        @(negedge clk);

        // Reset at E0+4 of a MUL aborts it.
        kick(OP_ADD, 8'h7F, 8'h01);
        chk("pre rst out", {8'h0, out}, 16'h0080);
        @(negedge clk);
        kick(OP_MUL, 8'h0F, 8'h11);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort busy",  {15'h0, busy},  16'h0000);
        chk("abort done",  {15'h0, done},  16'h0000);
        chk("abort out",   {8'h0, out},    16'h0000);
        chk("abort flags", {12'h0, flags}, 16'h0000);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("abort no done", ndone[15:0], 16'd0);

        // Output enable.
        kick(OP_OR, 8'h12, 8'h40);
        chk("oe on", {8'h0, out}, 16'h0052);
        in_enable_out = 1'b0;
        #1;
        n_cmp++;
        assert (out === 8'hzz) else begin
            n_err++;
            $error("FAIL oe off: observed %0h expected zz", out);
        end
        in_enable_out = 1'b1;
        #1;
        chk("oe restore", {8'h0, out}, 16'h0052);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand/result width (minimum 4).
REQ-002 The block SHALL have parameter SHAMT_W, default $clog2(WIDTH)+1, giving the width of the shift-amount field taken from in_B.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only when busy=0.
REQ-006 op  input  4  operation code.
REQ-007 in_A, in_B  input  WIDTH  operands.
REQ-008 in_enable_out  input  1  drives out when 1; out is high-impedance when 0.
REQ-009 out  output  WIDTH  registered result.
REQ-010 flags  output  4  registered {C,N,O,Z}.
REQ-011 busy  output  1  multi-cycle operation in progress.
REQ-012 done  output  1  one-cycle pulse when out and flags update.

Function
REQ-013 Opcodes SHALL be: 0 ADD, 1 SUB, 2 OR, 3 AND, 4 NOT A, 5 CMP (result 1 if A==B else 0), 6 SHR, 7 SHL, 8 ADC (A+B+C), 9 SBC (A-B-C), 10 MUL (low WIDTH bits), 11 XOR; opcodes 12-15 are reserved.
REQ-014 The start edge E0 is a rising edge where start=1 and busy=0; start while busy=1 SHALL be ignored without effect.
REQ-015 Single-cycle ops (0-5, 8, 9, 11, reserved) SHALL register out/flags at E0; done=1 in the following cycle and busy stays 0.
REQ-016 SHR/SHL SHALL shift by amount a=min(in_B[SHAMT_W-1:0], WIDTH), one bit per edge on E0+1..E0+a, with result published at E0+a; a=0 SHALL behave as a single-cycle op returning A.
REQ-017 MUL SHALL use shift-add, one partial product per edge on E0+1..E0+WIDTH, with result published at E0+WIDTH.
REQ-018 busy SHALL be 1 from the cycle after E0 until the cycle done is high, excluding that cycle; busy and done SHALL never both be 1.
REQ-019 The state machine SHALL have states IDLE, SHIFT and MUL: IDLE goes to SHIFT on a shift start with a>0 or to MUL on a MUL start, and returns to IDLE on the publish edge; a new start is accepted in the done cycle.
REQ-020 C flag: carry-out of the WIDTH+1-bit sum for ADD/ADC; bit WIDTH of the WIDTH+1-bit difference (borrow) for SUB/SBC; last bit shifted out for shifts; 1 if the high product half is nonzero for MUL; 0 otherwise.
REQ-021 O flag: signed overflow for ADD/ADC/SUB/SBC; 0 otherwise.
REQ-022 N flag SHALL equal out[WIDTH-1]; Z flag SHALL be 1 when out==0.
REQ-023 Reserved opcodes SHALL publish out=0 with flags unchanged and still pulse done.
REQ-024 out and flags SHALL hold between publishes; intermediate shift/mul values SHALL never appear on out.
REQ-025 ADC/SBC SHALL use the registered C from the previous publish.

Reset
REQ-026 While reset=1 at an edge: state=IDLE, out register=0, flags=0, busy=0, done=0.
REQ-027 Reset during SHIFT/MUL SHALL abort the operation; no done pulse for the aborted op.
REQ-028 Reset SHALL take priority over start on the same edge.

Structure
REQ-029 Package seq_alu_pkg SHALL hold the opcode constants, the state enum, and flag bit indices (C=3, N=2, O=1, Z=0).
REQ-030 Single-cycle datapath SHALL be sub-module alu_comb_core (combinational result plus C/O); the FSM, shifter and multiplier SHALL live in seq_alu.

Verification (WIDTH=8)
REQ-031 ADD 0x7F,0x01 -> out 0x80, flags C0 N1 O1 Z0; done in the cycle after E0.
REQ-032 ADD 0xFF,0x01 -> out 0x00, C1 Z1; then ADC 0x00,0x00 -> out 0x01, C0; SUB 0x00,0x01 -> out 0xFF, C1 N1.
REQ-033 SHL 0x81 by 3 -> busy 3 cycles, out 0x08, C0, done at E0+3; SHR 0x01 by 1 -> out 0x00, C1 Z1.
REQ-034 MUL 0x0F,0x11 -> out 0xFF, C0 after 8 steps; MUL 0x10,0x10 -> out 0x00, C1 Z1.
REQ-035 start pulsed during MUL -> ignored; only one done, and the result matches the first op.
REQ-036 reset asserted at E0+4 of MUL -> busy 0 next cycle, out 0x00, flags 0, no done; in_enable_out=0 -> out high-impedance.
